// File: rtl/mips_pkg.sv
// Shared definitions for the single-issue MIPS core: opcodes, the NOP word and the
// instruction-fetch FSM state type.
package mips_pkg;

   localparam logic [5:0]  OP_BEQ   = 6'b000100;
   localparam logic [5:0]  OP_ADDI  = 6'b001000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      HOLD,
      DRAIN,
      HALT
   } ifu_state_t;

   // A beq whose immediate is -1 targets itself: the program's idle loop.
   function automatic logic is_self_loop_beq(input logic [31:0] word);
      return (word[31:26] == OP_BEQ) && (word[15:0] == 16'hFFFF);
   endfunction

endpackage

// File: rtl/ifu_branch_target.sv
// PC-relative branch target: base + 4 + (sext(imm) << 2), wrapping modulo 2^PC_W.
// Purely combinational so the execute stage can reuse it.
module ifu_branch_target #(
   parameter int PC_W = 32
) (
   input  logic [PC_W-1:0] base_pc,
   input  logic [15:0]     imm,
   output logic [PC_W-1:0] target
);

   logic [PC_W-1:0] offset;

   assign offset = {{(PC_W-18){imm[15]}}, imm, 2'b00};
   assign target = base_pc + PC_W'(4) + offset;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and hands words
// to decode over valid/ready. Optional halt on branch-to-self: IFU_SELF_LOOP_HALT_EN.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     machinecode,
   output logic [PC_W-1:0] instr_pc,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_base_pc,
   input  logic [15:0]     br_imm,
   output logic            halted
);

   ifu_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            imem_req_q, imem_req_d;
   logic [PC_W-1:0] imem_addr_q, imem_addr_d;
   logic            instr_valid_q, instr_valid_d;
   logic [31:0]     machinecode_q, machinecode_d;
   logic [PC_W-1:0] instr_pc_q, instr_pc_d;
   logic [PC_W-1:0] br_target;
   logic            handshake;
   logic            self_halt;

   ifu_branch_target #(.PC_W(PC_W)) u_branch_target (
      .base_pc (br_base_pc),
      .imm     (br_imm),
      .target  (br_target)
   );

   assign handshake = (state_q == HOLD) && instr_ready;

`ifdef IFU_SELF_LOOP_HALT_EN
   assign self_halt = handshake && is_self_loop_beq(machinecode_q);
`else
   assign self_halt = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d       = state_q;
      pc_d          = pc_q;
      machinecode_d = machinecode_q;
      instr_pc_d    = instr_pc_q;

      unique case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: state_d = WAIT;
         WAIT: begin
            if (imem_rvalid) begin
               machinecode_d = imem_rdata;
               instr_pc_d    = pc_q;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            if (handshake) begin
               pc_d    = pc_q + PC_W'(4);
               state_d = FETCH;
            end
         end
         DRAIN: if (imem_rvalid) state_d = FETCH;
         HALT:  state_d = HALT;
         default: state_d = IDLE;
      endcase

      // Redirects override everything except the self-loop halt, which makes HALT terminal.
      if (self_halt) begin
         state_d = HALT;
      end else if (br_taken && (state_q != HALT)) begin
         pc_d = br_target;
         unique case (state_q)
            FETCH: state_d = DRAIN;
            WAIT: begin
               machinecode_d = machinecode_q;
               instr_pc_d    = instr_pc_q;
               state_d       = imem_rvalid ? FETCH : DRAIN;
            end
            HOLD:    state_d = FETCH;
            default: ;
         endcase
      end

      // Outputs are derived from the next state so they come straight out of flops.
      imem_req_d    = (state_d == FETCH);
      imem_addr_d   = (state_d == FETCH) ? pc_d : imem_addr_q;
      instr_valid_d = (state_d == HOLD);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         imem_req_q    <= 1'b0;
         imem_addr_q   <= RESET_PC;
         instr_valid_q <= 1'b0;
         machinecode_q <= NOP_WORD;
         instr_pc_q    <= RESET_PC;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         imem_req_q    <= imem_req_d;
         imem_addr_q   <= imem_addr_d;
         instr_valid_q <= instr_valid_d;
         machinecode_q <= machinecode_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

`ifdef IFU_SELF_LOOP_HALT_EN
   logic halted_q, halted_d;

   assign halted_d = (state_d == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) halted_q <= 1'b0;
      else        halted_q <= halted_d;
   end

   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign instr_valid = instr_valid_q;
   assign machinecode = machinecode_q;
   assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: imem model with programmable latency, expected fetch
// addresses and delivered words queued by the stimulus and popped by an independent monitor.
module tb_instr_fetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_instr_t;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] machinecode;
   logic [31:0] instr_pc;
   logic        br_taken;
   logic [31:0] br_base_pc;
   logic [15:0] br_imm;
   logic        halted;

   int          total = 0;
   int          bad   = 0;
   int          lat   = 1;
   int          mem_cnt;
   logic [31:0] mem_addr;

   logic [31:0] exp_fetch[$];
   exp_instr_t  exp_instr[$];

   instr_fetch_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .machinecode (machinecode),
      .instr_pc    (instr_pc),
      .br_taken    (br_taken),
      .br_base_pc  (br_base_pc),
      .br_imm      (br_imm),
      .halted      (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h0000_0000: rom = 32'h2009_0004;
         32'h0000_0004: rom = 32'h200A_0004;
         32'h0000_0008: rom = 32'h0109_5020;
         32'h0000_000C: rom = 32'h112A_FFFF;
         32'h0000_0010: rom = 32'h0000_0000;
         32'h0000_0018: rom = 32'h214A_0001;
         32'hFFFE_0004: rom = 32'h2008_0001;
         32'hFFFE_0008: rom = 32'h2108_0002;
         default:       rom = ~a;
      endcase
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %h with nothing expected", nm, act);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_fetch(input logic [31:0] a);
      exp_fetch.push_back(a);
   endtask

   task automatic push_instr(input logic [31:0] a);
      exp_instr_t e;
      e.pc   = a;
      e.word = rom(a);
      exp_instr.push_back(e);
   endtask

   task automatic wait_valid_pc(input logic [31:0] pc, input string nm);
      logic found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (instr_valid === 1'b1 && instr_pc === pc) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check(nm, 32'(found), 32'd1);
   endtask

   task automatic wait_req_addr(input logic [31:0] a, input string nm);
      logic found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (imem_req === 1'b1 && imem_addr === a) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check(nm, 32'(found), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},    32'(imem_req),    32'd0);
      check({tag, "_addr"},   imem_addr,        32'h0);
      check({tag, "_valid"},  32'(instr_valid), 32'd0);
      check({tag, "_mc"},     machinecode,      32'h0);
      check({tag, "_pc"},     instr_pc,         32'h0);
      check({tag, "_halted"}, 32'(halted),      32'd0);
   endtask

   // Instruction memory: one response exactly lat cycles after each request.
   initial begin
      mem_cnt     = 0;
      mem_addr    = '0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (!rst_n) begin
            mem_cnt = 0;
         end else begin
            if (mem_cnt > 0) begin
               mem_cnt--;
               if (mem_cnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = rom(mem_addr);
               end
            end
            if (imem_req === 1'b1) begin
               check("one_outstanding", 32'(mem_cnt), 32'd0);
               mem_cnt  = lat;
               mem_addr = imem_addr;
            end
         end
      end
   end

   // Monitor: every request and every handshake must match the next queued expectation.
   initial begin
      exp_instr_t e;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n === 1'b1) begin
            if (imem_req === 1'b1) begin
               if (exp_fetch.size() == 0) begin
                  fail_now("unexpected_fetch", imem_addr);
               end else begin
                  a = exp_fetch.pop_front();
                  check("fetch_addr", imem_addr, a);
               end
            end
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
               if (exp_instr.size() == 0) begin
                  fail_now("unexpected_instr", instr_pc);
               end else begin
                  e = exp_instr.pop_front();
                  check("instr_pc", instr_pc, e.pc);
                  check("instr_word", machinecode, e.word);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      instr_ready = 1'b1;
      br_taken    = 1'b0;
      br_base_pc  = '0;
      br_imm      = '0;
      lat         = 1;
      step();
      step();
      check_reset_outputs("rst0");

      // Release: IDLE, then a request for RESET_PC, word valid on the fourth cycle.
      push_fetch(32'h0);
      push_instr(32'h0);
      push_fetch(32'h4);
      push_instr(32'h4);
      rst_n = 1'b1;
      #1;
      check("idle_no_req", 32'(imem_req), 32'd0);
      step();
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'h0);
      step();
      check("wait_no_valid", 32'(instr_valid), 32'd0);
      step();
      check("first_valid", 32'(instr_valid), 32'd1);
      check("first_mc", machinecode, 32'h2009_0004);
      check("first_pc", instr_pc, 32'h0);
      step();
      instr_ready = 1'b0;

      // Stall in HOLD: word at 0x4 must stay put while ready is low.
      wait_valid_pc(32'h4, "reach_hold_4");
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_mc", machinecode, 32'h200A_0004);
         check("stall_pc", instr_pc, 32'h4);
         check("stall_no_req", 32'(imem_req), 32'd0);
         step();
      end

      lat = 4;
      push_fetch(32'h8);
      push_fetch(32'h18);
      push_instr(32'h18);
      push_fetch(32'h1C);
      push_fetch(32'hFFFE_0004);
      push_instr(32'hFFFE_0004);
      push_fetch(32'hFFFE_0008);
      push_instr(32'hFFFE_0008);
      push_fetch(32'h8);
      push_instr(32'h8);
      push_fetch(32'hC);
      push_instr(32'hC);
`ifndef IFU_SELF_LOOP_HALT_EN
      push_fetch(32'h10);
`endif
      instr_ready = 1'b1;
      step();
      check("next_req", 32'(imem_req), 32'd1);
      check("next_addr", imem_addr, 32'h8);

      // Redirect while WAITing: the in-flight 0x8 word is stale and must be dropped.
      step();
      br_taken   = 1'b1;
      br_base_pc = 32'h8;
      br_imm     = 16'h0003;
      step();
      br_taken = 1'b0;
      wait_valid_pc(32'h18, "redirect_wait_pc");
      check("redirect_wait_mc", machinecode, 32'h214A_0001);

      // Redirect in FETCH with a negative immediate that wraps below zero.
      wait_req_addr(32'h1C, "req_1c");
      br_taken   = 1'b1;
      br_base_pc = 32'h0;
      br_imm     = 16'h8000;
      step();
      br_taken = 1'b0;
      wait_valid_pc(32'hFFFE_0004, "wrap_target_pc");
      check("wrap_target_mc", machinecode, 32'h2008_0001);

      // Redirect in HOLD with a same-cycle handshake; target wraps above 2^32 back to 0x8.
      wait_valid_pc(32'hFFFE_0008, "hold_br_pc");
      br_taken   = 1'b1;
      br_base_pc = 32'hFFFE_0008;
      br_imm     = 16'h7FFF;
      step();
      br_taken = 1'b0;
      check("hold_br_valid_drop", 32'(instr_valid), 32'd0);
      check("hold_br_req", 32'(imem_req), 32'd1);
      check("hold_br_addr", imem_addr, 32'h8);

      // Branch-to-self accepted.
      wait_valid_pc(32'hC, "self_loop_pc");
      step();
`ifdef IFU_SELF_LOOP_HALT_EN
      for (int i = 0; i < 20; i++) begin
         check("halt_flag", 32'(halted), 32'd1);
         check("halt_no_req", 32'(imem_req), 32'd0);
         check("halt_no_valid", 32'(instr_valid), 32'd0);
         step();
      end
`else
      check("no_halt_flag", 32'(halted), 32'd0);
      check("no_halt_req", 32'(imem_req), 32'd1);
      check("no_halt_addr", imem_addr, 32'h10);
`endif
      instr_ready = 1'b0;
      step();
      step();

      // Reset out of HALT / HOLD, then again mid-HOLD after a fresh fetch.
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst1");
      exp_fetch.delete();
      exp_instr.delete();
      step();
      step();
      lat = 3;
      push_fetch(32'h0);
      rst_n = 1'b1;
      wait_valid_pc(32'h0, "refetch_hold");
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst2");
      exp_fetch.delete();
      exp_instr.delete();
      step();
      push_fetch(32'h0);
      push_instr(32'h0);
      push_fetch(32'h4);
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      wait_valid_pc(32'h0, "restart_pc");
      check("restart_mc", machinecode, 32'h2009_0004);
      step();
      instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();

      check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
      check("instr_queue_empty", 32'(exp_instr.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
